// File: rtl/npn_tt_capture_if.sv
// Bus between the truth-table capture engine and the checking bench:
// start/expect request, minterm drive, y sample and result handshake.
interface npn_tt_capture_if;
  logic        start;
  logic [15:0] expect_tt;
  logic [3:0]  x;
  logic        y;
  logic        busy;
  logic        tt_valid;
  logic        tt_ready;
  logic [15:0] tt_data;
  logic [4:0]  tt_ones;
  logic        tt_match;

  modport master (
    output start, expect_tt, y, tt_ready,
    input  x, busy, tt_valid, tt_data, tt_ones, tt_match
  );

  modport slave (
    input  start, expect_tt, y, tt_ready,
    output x, busy, tt_valid, tt_data, tt_ones, tt_match
  );
endinterface

// File: rtl/npn_tt_capture.sv
// Walks x through all 16 minterms of a 4-input network, samples y after
// SETTLE extra cycles per minterm and returns the assembled truth table.
module npn_tt_capture #(
  parameter int unsigned SETTLE = 0
) (
  input logic              clk,
  input logic              rst_n,
  npn_tt_capture_if.slave  tt_if
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_idx, r_cnt;
  logic [15:0] r_exp, r_data;
  logic [4:0]  r_ones;
  logic        r_match, r_busy, r_valid;

  logic        w_accept, w_sample, w_last;
  logic [15:0] w_data_smp;

  assign w_accept = (r_state == S_IDLE) && tt_if.start;
  assign w_sample = (r_state == S_RUN) && (r_cnt == SETTLE_C);
  assign w_last   = w_sample && (r_idx == 4'd15);

  // Table with the current minterm's y merged in; match must see the final bit.
  always_comb begin
    w_data_smp        = r_data;
    w_data_smp[r_idx] = tt_if.y;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (tt_if.start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (r_valid && tt_if.tt_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_data  <= '0;
      r_ones  <= '0;
      r_match <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nxt != S_IDLE);
      r_valid <= (w_state_nxt == S_DONE);
      if (w_accept) begin
        r_exp   <= tt_if.expect_tt;
        r_data  <= '0;
        r_ones  <= '0;
        r_match <= 1'b0;
        r_idx   <= '0;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        if (!w_sample) begin
          r_cnt <= r_cnt + 4'd1;
        end else begin
          r_cnt  <= '0;
          r_data <= w_data_smp;
          r_ones <= r_ones + 5'(tt_if.y);
          // idx stops at 15 so x keeps showing the last minterm afterwards.
          if (!w_last) r_idx   <= r_idx + 4'd1;
          else         r_match <= (w_data_smp == r_exp);
        end
      end
    end
  end

  assign tt_if.x        = r_idx;
  assign tt_if.busy     = r_busy;
  assign tt_if.tt_valid = r_valid;
  assign tt_if.tt_data  = r_data;
  assign tt_if.tt_ones  = r_ones;
  assign tt_if.tt_match = r_match;

endmodule
